// File: rtl/axis_serdes_pkg.sv
// Shared types and helpers for the SERDES-side AXI-Stream blocks.
//   arb_state_t : arbiter FSM state (idle / grant held)
//   clog2_min1  : ceil(log2(n)) but never less than 1, for index/counter widths
package axis_serdes_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_fifo_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req     : request vector, one bit per source
//   ptr     : highest-priority index; search runs upward from here, wrapping
//   idx     : first requesting index at or after ptr (0 when nothing requests)
//   any_req : at least one request bit is set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any_req
);

  logic [IW-1:0] k;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    idx     = '0;
    k       = '0;
    any_req = |req;
    for (int i = N - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N);
      if (req[k]) idx = k;
    end
  end

endmodule

// File: rtl/axis_fifo_arbiter.sv
// axis_fifo_arbiter: packet-locked round-robin arbiter sharing one FIFO write
// port between NUM_SRC AXI-Stream sources (write-clock domain).
//   i_clk, i_rst           : write clock, async active-high reset
//   i_s_tvalid/tdata/tlast : per-source stream inputs (source k at [k*DATA_W +: DATA_W])
//   o_s_tready             : per-source ready, one-hot or zero
//   o_wr, o_wdata, i_wfull : FIFO write interface
//   o_busy, o_grant        : grant held / granted source index
// Optional: define AXIS_ARB_SRCID_EN to prepend the source index to o_wdata.
module axis_fifo_arbiter
  import axis_serdes_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 0,
  localparam int ID_W     = clog2_min1(NUM_SRC),
`ifdef AXIS_ARB_SRCID_EN
  localparam int OUT_W    = DATA_W + ID_W
`else
  localparam int OUT_W    = DATA_W
`endif
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_SRC-1:0]        i_s_tvalid,
  input  logic [NUM_SRC*DATA_W-1:0] i_s_tdata,
  input  logic [NUM_SRC-1:0]        i_s_tlast,
  output logic [NUM_SRC-1:0]        o_s_tready,
  output logic                      o_wr,
  output logic [OUT_W-1:0]          o_wdata,
  input  logic                      i_wfull,
  output logic                      o_busy,
  output logic [ID_W-1:0]           o_grant
);

  localparam int CNT_W = clog2_min1(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);

  arb_state_t        state, state_nxt;
  logic [ID_W-1:0]   grant, grant_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]   pick;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic              any_req;
  logic [DATA_W-1:0] g_data;

  rr_pick #(.N(NUM_SRC), .IW(ID_W)) u_pick (
    .req     (i_s_tvalid),
    .ptr     (rr_ptr),
    .idx     (pick),
    .any_req (any_req)
  );

  assign g_data  = i_s_tdata[grant*DATA_W +: DATA_W];
  assign o_busy  = (state == ARB_GRANT);
  assign o_grant = grant;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    o_s_tready   = '0;
    o_wr         = 1'b0;
    o_wdata      = '0;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          grant_nxt    = pick;
          beat_cnt_nxt = '0;
          state_nxt    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        // Full is honoured in the same cycle: no ready, no write, no beat.
        o_s_tready[grant] = !i_wfull;
        o_wr              = i_s_tvalid[grant] & !i_wfull;
        if (o_wr) begin
`ifdef AXIS_ARB_SRCID_EN
          o_wdata = {grant, g_data};
`else
          o_wdata = g_data;
`endif
          // Saturate so an unlimited grant never wraps the counter.
          if (beat_cnt != '1) beat_cnt_nxt = beat_cnt + 1'b1;
          if (i_s_tlast[grant] || (MAX_BEATS != 0 && beat_cnt == CNT_LAST)) begin
            rr_ptr_nxt = ID_W'((int'(grant) + 1) % NUM_SRC);
            state_nxt  = ARB_IDLE;
          end
        end
      end
    endcase
  end

endmodule
